// File: rtl/timed_counter_pkg.sv
// rtl/timed_counter_pkg.sv - shared types, mode constants and saturating add for the timed counters
package timed_counter_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam string MODE_NORMAL = "NORMAL";
    localparam string MODE_ACK    = "ACKNOWLEDGE";
    localparam string PIPE_TRUE   = "TRUE";

    // Returns {overflow, sum}; only the low w bits of the sum are meaningful (w <= 32).
    function automatic logic [32:0] sat_add(input logic [31:0] acc, input logic inc,
                                            input int unsigned w);
        logic [31:0] max_val;
        max_val = 32'hFFFF_FFFF >> (32 - w);
        if (inc && (acc == max_val)) begin
            return {1'b1, acc};
        end
        return {1'b0, acc + {31'd0, inc}};
    endfunction

endpackage

// File: rtl/timed_counter_chan.sv
// rtl/timed_counter_chan.sv - one saturating event counter channel with sticky flag and snapshot
module timed_counter_chan
    import timed_counter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             snap,
    output logic [CNT_W-1:0] count,
    output logic             sat_out
);

    logic [CNT_W-1:0] acc;
    logic             sat;
    logic [32:0]      add_res;
    logic [CNT_W-1:0] sum;
    logic             ovf;

    always_comb begin
        add_res = sat_add(32'(acc), inc, unsigned'(CNT_W));
        sum     = add_res[CNT_W-1:0];
        ovf     = add_res[32];
    end

    // The terminal cycle's own increment is folded into the snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            sat     <= 1'b0;
            count   <= '0;
            sat_out <= 1'b0;
        end else if (snap) begin
            count   <= sum;
            sat_out <= sat | ovf;
            acc     <= '0;
            sat     <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            sat <= 1'b0;
        end else begin
            acc <= sum;
            sat <= sat | ovf;
        end
    end

endmodule

// File: rtl/multi_timed_counter.sv
// rtl/multi_timed_counter.sv - NCHAN event counters snapshotted together by one interval timer
module multi_timed_counter
    import timed_counter_pkg::*;
#(
    parameter int    NCHAN             = 4,
    parameter int    CNT_W             = 16,
    parameter int    INTERVAL_W        = 24,
    parameter int    DEFAULT_INTERVAL  = 0,
    parameter string MODE              = "NORMAL",
    parameter string COUNT_IN_PIPELINE = "TRUE"
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCHAN-1:0]       count_in,
    input  logic [INTERVAL_W-1:0]  interval_in,
    input  logic                   interval_load,
    input  logic                   ack,
    output logic [NCHAN*CNT_W-1:0] count_out,
    output logic [NCHAN-1:0]       count_sat,
    output logic                   count_out_valid
);

    localparam bit ACK_MODE = (MODE == MODE_ACK);

    logic [INTERVAL_W-1:0] interval_reg;
    logic [INTERVAL_W-1:0] timer;
    state_t                state;
    logic [NCHAN-1:0]      cin;
    logic [NCHAN-1:0]      inc;
    logic                  terminal;
    logic                  snap;

    generate
        if (COUNT_IN_PIPELINE == PIPE_TRUE) begin : g_pipe
            logic [NCHAN-1:0] cin_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) cin_q <= '0;
                else     cin_q <= count_in;
            end
            assign cin = cin_q;
        end else begin : g_nopipe
            assign cin = count_in;
        end
    endgenerate

    // Interval 0 falls out naturally: timer+1 wraps to 0 after 2^INTERVAL_W cycles.
    assign terminal = (state == ST_RUN) && ((timer + INTERVAL_W'(1)) == interval_reg);
    assign snap     = terminal && !interval_load;
    assign inc      = cin & {NCHAN{state == ST_RUN}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            interval_reg    <= INTERVAL_W'(DEFAULT_INTERVAL);
            timer           <= '0;
            state           <= ST_RUN;
            count_out_valid <= 1'b0;
        end else if (interval_load) begin
            interval_reg    <= interval_in;
            timer           <= '0;
            state           <= ST_RUN;
            count_out_valid <= 1'b0;
        end else if (snap) begin
            timer           <= '0;
            count_out_valid <= 1'b1;
            if (ACK_MODE) state <= ST_HOLD;
        end else if (state == ST_RUN) begin
            timer           <= timer + INTERVAL_W'(1);
            count_out_valid <= 1'b0;
        end else if (ack) begin
            count_out_valid <= 1'b0;
            state           <= ST_RUN;
        end
    end

    genvar i;
    generate
        for (i = 0; i < NCHAN; i++) begin : g_chan
            timed_counter_chan #(
                .CNT_W(CNT_W)
            ) u_chan (
                .clk     (clk),
                .rst     (rst),
                .inc     (inc[i]),
                .clr     (interval_load),
                .snap    (snap),
                .count   (count_out[i*CNT_W +: CNT_W]),
                .sat_out (count_sat[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_timed_counter.sv
// tb/tb_multi_timed_counter.sv - directed bench over three parameterisations of multi_timed_counter
module tb_multi_timed_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // A: NORMAL, narrow counts, no input pipeline
    logic [3:0]  a_count_in = '0;
    logic [7:0]  a_interval_in = '0;
    logic        a_load = 1'b0, a_ack = 1'b0;
    logic [15:0] a_out;
    logic [3:0]  a_sat;
    logic        a_valid;

    // B: ACKNOWLEDGE, pipelined input
    logic [3:0]  b_count_in = '0;
    logic [23:0] b_interval_in = '0;
    logic        b_load = 1'b0, b_ack = 1'b0;
    logic [63:0] b_out;
    logic [3:0]  b_sat;
    logic        b_valid;

    // C: NORMAL, 4-bit interval timer
    logic [1:0]  c_count_in = '0;
    logic [3:0]  c_interval_in = '0;
    logic        c_load = 1'b0, c_ack = 1'b0;
    logic [9:0]  c_out;
    logic [1:0]  c_sat;
    logic        c_valid;

    multi_timed_counter #(.NCHAN(4), .CNT_W(4), .INTERVAL_W(8), .DEFAULT_INTERVAL(6),
                          .MODE("NORMAL"), .COUNT_IN_PIPELINE("FALSE")) dut_a (
        .clk(clk), .rst(rst), .count_in(a_count_in), .interval_in(a_interval_in),
        .interval_load(a_load), .ack(a_ack), .count_out(a_out), .count_sat(a_sat),
        .count_out_valid(a_valid));

    multi_timed_counter #(.NCHAN(4), .CNT_W(16), .INTERVAL_W(24), .DEFAULT_INTERVAL(5),
                          .MODE("ACKNOWLEDGE"), .COUNT_IN_PIPELINE("TRUE")) dut_b (
        .clk(clk), .rst(rst), .count_in(b_count_in), .interval_in(b_interval_in),
        .interval_load(b_load), .ack(b_ack), .count_out(b_out), .count_sat(b_sat),
        .count_out_valid(b_valid));

    multi_timed_counter #(.NCHAN(2), .CNT_W(5), .INTERVAL_W(4), .DEFAULT_INTERVAL(0),
                          .MODE("NORMAL"), .COUNT_IN_PIPELINE("FALSE")) dut_c (
        .clk(clk), .rst(rst), .count_in(c_count_in), .interval_in(c_interval_in),
        .interval_load(c_load), .ack(c_ack), .count_out(c_out), .count_sat(c_sat),
        .count_out_valid(c_valid));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        check("rst_a_out", 64'(a_out), 64'h0);
        check("rst_a_valid", 64'(a_valid), 64'h0);
        check("rst_b_out", b_out, 64'h0);
        check("rst_c_sat", 64'(c_sat), 64'h0);
        rst = 1'b0;

        // B: interval 3, all channels high, hold until ack; ack in RUN ignored
        b_count_in = 4'b1111;
        b_interval_in = 24'd3;
        b_load = 1'b1;
        step();
        b_load = 1'b0;
        b_ack = 1'b1;
        step();
        b_ack = 1'b0;
        step();
        check("b_pre_valid", 64'(b_valid), 64'h0);
        step();
        check("b_snap_valid", 64'(b_valid), 64'h1);
        check("b_snap_out", b_out, 64'h0003_0003_0003_0003);
        for (int k = 0; k < 10; k++) begin
            step();
            check("b_hold_valid", 64'(b_valid), 64'h1);
            check("b_hold_out", b_out, 64'h0003_0003_0003_0003);
        end
        b_ack = 1'b1;
        step();
        b_ack = 1'b0;
        check("b_ack_valid", 64'(b_valid), 64'h0);
        step();
        step();
        check("b_rerun_valid", 64'(b_valid), 64'h0);
        step();
        check("b_resnap_valid", 64'(b_valid), 64'h1);
        check("b_resnap_out", b_out, 64'h0003_0003_0003_0003);

        // A: interval 4, pattern 0101
        a_count_in = 4'b0101;
        a_interval_in = 8'd4;
        a_load = 1'b1;
        step();
        a_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("a4_wait_valid", 64'(a_valid), 64'h0);
        end
        step();
        check("a4_valid", 64'(a_valid), 64'h1);
        check("a4_out", 64'(a_out), 64'h0404);
        check("a4_sat", 64'(a_sat), 64'h0);
        step();
        check("a4_pulse_end", 64'(a_valid), 64'h0);
        step();
        step();
        step();
        check("a4_second_valid", 64'(a_valid), 64'h1);
        check("a4_second_out", 64'(a_out), 64'h0404);

        // A: interval 1 gives continuous valid with count 1
        a_count_in = 4'b0001;
        a_interval_in = 8'd1;
        a_load = 1'b1;
        step();
        a_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("a1_valid", 64'(a_valid), 64'h1);
            check("a1_out", 64'(a_out), 64'h0001);
        end

        // A: interval 20 saturates a 4-bit channel, then interval 10 does not
        a_interval_in = 8'd20;
        a_load = 1'b1;
        step();
        a_load = 1'b0;
        for (int k = 0; k < 19; k++) step();
        check("a20_wait_valid", 64'(a_valid), 64'h0);
        step();
        check("a20_valid", 64'(a_valid), 64'h1);
        check("a20_out", 64'(a_out), 64'h000F);
        check("a20_sat", 64'(a_sat), 64'h1);
        a_interval_in = 8'd10;
        a_load = 1'b1;
        step();
        a_load = 1'b0;
        check("a10_load_valid", 64'(a_valid), 64'h0);
        for (int k = 0; k < 10; k++) step();
        check("a10_valid", 64'(a_valid), 64'h1);
        check("a10_out", 64'(a_out), 64'h000A);
        check("a10_sat", 64'(a_sat), 64'h0);

        // A: load on the terminal cycle suppresses the snapshot
        a_interval_in = 8'd4;
        a_load = 1'b1;
        step();
        a_load = 1'b0;
        step();
        step();
        step();
        a_interval_in = 8'd2;
        a_load = 1'b1;
        step();
        a_load = 1'b0;
        check("ald_valid", 64'(a_valid), 64'h0);
        check("ald_out_kept", 64'(a_out), 64'h000A);
        step();
        check("ald_wait_valid", 64'(a_valid), 64'h0);
        step();
        check("ald2_valid", 64'(a_valid), 64'h1);
        check("ald2_out", 64'(a_out), 64'h0002);
        a_interval_in = 8'd7;
        step();
        check("anl_wait_valid", 64'(a_valid), 64'h0);
        step();
        check("anl_valid", 64'(a_valid), 64'h1);
        check("anl_out", 64'(a_out), 64'h0002);

        // C: interval 0 means 16 cycles
        c_count_in = 2'b01;
        c_interval_in = 4'd0;
        c_load = 1'b1;
        step();
        c_load = 1'b0;
        for (int k = 0; k < 15; k++) step();
        check("c0_wait_valid", 64'(c_valid), 64'h0);
        step();
        check("c0_valid", 64'(c_valid), 64'h1);
        check("c0_out", 64'(c_out), 64'h010);
        check("c0_sat", 64'(c_sat), 64'h0);

        // Async reset with A on a valid cycle and B in HOLD
        a_interval_in = 8'd2;
        a_load = 1'b1;
        step();
        a_load = 1'b0;
        step();
        step();
        check("pre_rst_a_valid", 64'(a_valid), 64'h1);
        check("pre_rst_b_valid", 64'(b_valid), 64'h1);
        rst = 1'b1;
        #1;
        check("arst_a_valid", 64'(a_valid), 64'h0);
        check("arst_a_out", 64'(a_out), 64'h0);
        check("arst_b_valid", 64'(b_valid), 64'h0);
        check("arst_b_out", b_out, 64'h0);
        check("arst_c_out", 64'(c_out), 64'h0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 5) begin
                check("post_a_wait_valid", 64'(a_valid), 64'h0);
                check("post_b_valid", 64'(b_valid), 64'h1);
                check("post_b_out", b_out, 64'h0004_0004_0004_0004);
            end
            if (k == 6) begin
                check("post_a_valid", 64'(a_valid), 64'h1);
                check("post_a_out", 64'(a_out), 64'h0006);
            end
            if (k == 15) check("post_c_wait_valid", 64'(c_valid), 64'h0);
            if (k == 16) begin
                check("post_c_valid", 64'(c_valid), 64'h1);
                check("post_c_out", 64'(c_out), 64'h010);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_timed_counter.md
Name: multi_timed_counter

Overview:
- Parametrised successor to the single-DSP timed counter: NCHAN independent event counters share one programmable interval timer.
- At each interval end, all channel counts are snapshotted together, then the counters restart.
- Adds configurable widths, saturation flags, and a dedicated acknowledge port that is separate from the async reset.
- Sits in monitoring and scaler paths, e.g. trigger-rate and housekeeping counters read across a clock crossing.

Parameters:
- NCHAN, 4: number of count channels (1..32).
- CNT_W, 16: per-channel count width.
- INTERVAL_W, 24: interval timer width.
- DEFAULT_INTERVAL, 0: interval register value after reset; 0 means 2^INTERVAL_W.
- MODE, "NORMAL": "NORMAL" = free-running windows; "ACKNOWLEDGE" = hold after each window until ack.
- COUNT_IN_PIPELINE, "TRUE": registers count_in once before counting, adding 1 cycle of input lag.

Ports:
- clk  in  1  main clock
- rst  in  1  asynchronous active-high reset
- count_in  in  NCHAN  per-channel increment enables
- interval_in  in  INTERVAL_W  window length in clocks; 0 = 2^INTERVAL_W
- interval_load  in  1  latch interval_in and restart the window
- ack  in  1  ACKNOWLEDGE mode only: release the held result and restart; ignored in NORMAL
- count_out  out  NCHAN*CNT_W  snapshot counts; channel i occupies bits [i*CNT_W +: CNT_W]
- count_sat  out  NCHAN  channel i saturated during the snapshotted window
- count_out_valid  out  1  NORMAL: 1-cycle flag; ACKNOWLEDGE: level until ack or load

Behaviour:
- Async reset clears: count_out=0, count_sat=0, count_out_valid=0, timer=0, all accumulators=0, state=RUN, input pipeline=0. Interval register resets to DEFAULT_INTERVAL.
- Define cin = count_in delayed one cycle when COUNT_IN_PIPELINE="TRUE", else count_in.
- RUN state, each cycle:
  - acc[i] += cin[i], saturating at 2^CNT_W-1; sticky sat[i] sets when an increment is blocked.
  - timer += 1, wrapping mod 2^INTERVAL_W.
- Terminal cycle: the cycle where timer+1 == interval (mod 2^INTERVAL_W). A window therefore spans exactly `interval` sampled cycles, with no dead cycle between windows.
- On the terminal cycle, registered:
  - count_out[i] <= sat_add(acc[i], cin[i]); count_sat[i] <= sat[i] | overflow of this add.
  - count_out_valid <= 1.
  - timer, acc and sat cleared.
- Latency: the valid flag is high on the cycle after the window's last sampled cycle.
- NORMAL mode:
  - valid is high for exactly 1 cycle per window; count_out holds its value until the next snapshot.
  - count_out_valid is deasserted on the cycle after it asserts.
- ACKNOWLEDGE mode:
  - After a snapshot, state=HOLD: timer and accumulators are frozen at 0, cin is ignored, valid stays high.
  - ack in HOLD: valid<=0, state<=RUN. The ack cycle samples no input; counting resumes on the next cycle.
  - ack in RUN is ignored. ack coincident with the terminal cycle is ignored, so the block still enters HOLD.
- interval_load, any state or mode:
  - interval_reg<=interval_in, timer<=0, acc<=0, sat<=0, valid<=0, state<=RUN.
  - The load cycle's cin is dropped (one dead cycle).
  - A load coincident with a terminal cycle wins: no snapshot occurs and count_out is unchanged.
  - A load together with ack behaves as a load.
- Interval 1: every sampled cycle is terminal, so count_out ∈{0,1} and valid is continuous in NORMAL mode.
- Interval 0: the window is 2^INTERVAL_W cycles.
- Changing interval_in without interval_load has no effect.
- Deassertion of rst is not synchronised internally; the integrator supplies a clean reset release.

Decomposition:
- Shared package `timed_counter_pkg`:
  - state encoding localparams (ST_RUN=0, ST_HOLD=1);
  - MODE string constants;
  - the sat_add function (width-generic saturating increment returning the overflow bit).
- Sub-module `timed_counter_chan`: one channel with saturating accumulator, sticky sat, and snapshot register.
  - Inputs: clk, rst, inc, clr, snap.
  - Instantiated NCHAN times by generate.
  - The top level owns the timer, interval register, state and valid.

Test Plan:
- NORMAL, load interval 4, count_in=4'b0101 constant, no pipeline → first valid 5 cycles after the load cycle, count_out ch0=4, ch1=0, ch2=4, ch3=0; then valid every 4 cycles with identical values.
- CNT_W=4, interval 20, ch0 held high → count_out ch0=15, count_sat[0]=1; next window of interval 10 gives count_out ch0=10, count_sat[0]=0.
- ACKNOWLEDGE, interval 3, all channels high → valid rises and stays high 10 cycles with counts=3 while input continues; ack pulse → valid low next cycle, next snapshot again 3 (ack cycle not counted).
- Load coincident with terminal cycle (interval 4 → new interval 2) → no snapshot, valid stays 0, next snapshot covers exactly 2 cycles.
- INTERVAL_W=4, interval_in=0 → window of 16 cycles, ch0 constant high reports 16 only if CNT_W≥5; with CNT_W=4 reports 15 with sat.
- Assert rst mid-window and in HOLD → all outputs 0 immediately (async), interval returns to DEFAULT_INTERVAL, counting resumes on the first clock after release.
